pulse_stretcher: RTL

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher.sv | 89 ++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle requests into fixed-length high levels separated by a
// fixed low gap, queuing up to three requests that arrive while busy.
module pulse_stretcher #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input  logic Clk,
   input  logic Rst,
   input  logic P_in,
   output logic L_out,
   output logic Busy,
   output logic Ovf
);

   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [1:0] pend, pend_nxt;
   logic       ovf_nxt;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         cnt   <= '0;
         pend  <= '0;
         L_out <= 1'b0;
         Busy  <= 1'b0;
         Ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pend  <= pend_nxt;
         L_out <= (state_nxt == HOLD);
         Busy  <= (state_nxt != IDLE);
         Ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pend_nxt  = pend;
      ovf_nxt   = Ovf;
      // requests while busy queue up; a full queue drops the request
      if (state != IDLE && P_in) begin
         if (pend == 2'd3) ovf_nxt  = 1'b1;
         else              pend_nxt = pend + 2'd1;
      end
      case (state)
         IDLE: begin
            if (P_in) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (cnt == 8'd0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_LOAD;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         GAP: begin
            if (cnt != 8'd0) begin
               cnt_nxt = cnt - 8'd1;
            end else if (pend != 2'd0 || P_in) begin
               // a request on the final gap cycle is added and consumed on the
               // same edge, so it can never overflow here
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LOAD;
               pend_nxt  = P_in ? pend : pend - 2'd1;
               ovf_nxt   = Ovf;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule
